// File: rtl/alu_sequencer_if.sv
// Signal bundle between alu_sequencer and its surroundings: host handshake,
// instruction memory port and the ALU drive/sample lines.
interface alu_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int ADDR_WIDTH   = 4
);
    localparam int IW = OPCODE_WIDTH + 2 + DATA_WIDTH;

    // Host handshake: i_start is a level request that only counts while the
    // sequencer is idle; o_busy/o_done/o_err/o_result/o_carry report status.
    logic                    i_start;
    logic [DATA_WIDTH-1:0]   i_init;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_err;
    logic [DATA_WIDTH-1:0]   o_result;
    logic                    o_carry;
    logic [ADDR_WIDTH-1:0]   o_imem_addr;
    logic [IW-1:0]           i_imem_data;
    logic [OPCODE_WIDTH-1:0] o_alu_op;
    logic [DATA_WIDTH-1:0]   o_alu_i_1;
    logic [DATA_WIDTH-1:0]   o_alu_i_2;
    logic                    o_alu_carry_in;
    logic [DATA_WIDTH-1:0]   i_alu_main;
    logic                    i_alu_carry;

    modport slave (
        input  i_start, i_init, i_imem_data, i_alu_main, i_alu_carry,
        output o_busy, o_done, o_err, o_result, o_carry, o_imem_addr,
               o_alu_op, o_alu_i_1, o_alu_i_2, o_alu_carry_in
    );

    modport master (
        output i_start, i_init, i_imem_data, i_alu_main, i_alu_carry,
        input  o_busy, o_done, o_err, o_result, o_carry, o_imem_addr,
               o_alu_op, o_alu_i_1, o_alu_i_2, o_alu_carry_in
    );
endinterface

// File: rtl/alu_sequencer.sv
// Micro-sequencer: fetches instruction words, drives one ALU and accumulates
// its result; each instruction takes FETCH, LOAD_IR and EXEC cycles.
module alu_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int ADDR_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    alu_sequencer_if.slave        bus,
    output logic [2:0]            dbg_state
);
    localparam int IW = OPCODE_WIDTH + 2 + DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD_IR = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [IW-1:0]         ir, ir_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic                  carry, carry_nxt;
    logic                  err, err_nxt;

    logic [OPCODE_WIDTH-1:0] ir_op;
    logic                    ir_c;
    logic                    ir_h;
    logic [DATA_WIDTH-1:0]   ir_imm;

    assign ir_op  = ir[IW-1 -: OPCODE_WIDTH];
    assign ir_c   = ir[DATA_WIDTH+1];
    assign ir_h   = ir[DATA_WIDTH];
    assign ir_imm = ir[DATA_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            acc   <= acc_nxt;
            carry <= carry_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        acc_nxt   = acc;
        carry_nxt = carry;
        err_nxt   = err;
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    pc_nxt    = '0;
                    acc_nxt   = bus.i_init;
                    carry_nxt = 1'b0;
                    err_nxt   = 1'b0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH:   state_nxt = S_LOAD_IR;
            S_LOAD_IR: begin
                ir_nxt    = bus.i_imem_data;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                acc_nxt   = bus.i_alu_main;
                carry_nxt = bus.i_alu_carry;
                // pc stops at the last slot; running past it is flagged, not wrapped.
                if (ir_h) begin
                    state_nxt = S_DONE;
                end else if (pc == {ADDR_WIDTH{1'b1}}) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    pc_nxt    = pc + 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decode only registered state, never the ALU inputs.
    assign bus.o_busy         = (state == S_FETCH) || (state == S_LOAD_IR) || (state == S_EXEC);
    assign bus.o_done         = (state == S_DONE);
    assign bus.o_err          = err;
    assign bus.o_result       = acc;
    assign bus.o_carry        = carry;
    assign bus.o_imem_addr    = pc;
    assign bus.o_alu_op       = ir_op;
    assign bus.o_alu_i_1      = acc;
    assign bus.o_alu_i_2      = ir_imm;
    assign bus.o_alu_carry_in = ir_c ? carry : 1'b0;
    assign dbg_state          = state;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and synchronous
// instruction memory; expected values are hand-computed per program.
module tb_alu_sequencer;
    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory (synchronous read)
    logic [12:0] mem [16];
    always_ff @(posedge clk) bus.i_imem_data <= mem[bus.o_imem_addr];

    // behavioural ALU
    always_comb begin
        bus.i_alu_main  = 8'h00;
        bus.i_alu_carry = 1'b0;
        case (bus.o_alu_op)
            3'd0: {bus.i_alu_carry, bus.i_alu_main} = {1'b0, bus.o_alu_i_1} + {1'b0, bus.o_alu_i_2}
                                                     + {8'h00, bus.o_alu_carry_in};
            3'd1: bus.i_alu_main = bus.o_alu_i_1 - bus.o_alu_i_2 + {7'h00, bus.o_alu_carry_in};
            3'd2: bus.i_alu_main = bus.o_alu_i_1 & bus.o_alu_i_2;
            3'd3: bus.i_alu_main = bus.o_alu_i_1 | bus.o_alu_i_2;
            3'd4: bus.i_alu_main = bus.o_alu_i_1 ^ bus.o_alu_i_2;
            3'd5: bus.i_alu_main = ~bus.o_alu_i_1;
            default: begin
                bus.i_alu_main  = bus.o_alu_i_2;
                bus.i_alu_carry = bus.o_alu_carry_in;
            end
        endcase
    end

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ins(input logic [2:0] op, input logic c, input logic h,
                                        input logic [7:0] imm);
        return {op, c, h, imm};
    endfunction

    // driver tasks
    logic [63:0] poke_mask;
    logic [7:0]  snap_res [64];
    logic        snap_car [64];
    logic        cin_seen;
    logic        busy_all;

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = ins(3'd0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic start_prog(input logic [7:0] init);
        @(negedge clk);
        bus.i_init  = init;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // Returns the cycle number (FETCH of instruction 0 is cycle 1) at which o_done is seen.
    task automatic wait_done(input int limit, output int cyc);
        cyc      = 1;
        cin_seen = 1'b0;
        busy_all = 1'b1;
        while (!bus.o_done && cyc < limit) begin
            snap_res[cyc] = bus.o_result;
            snap_car[cyc] = bus.o_carry;
            cin_seen      = cin_seen | bus.o_alu_carry_in;
            busy_all      = busy_all & bus.o_busy;
            bus.i_start   = poke_mask[cyc];
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.i_start = 1'b0;
        if (!bus.o_done) check("done_timeout", 32'(cyc), 32'(limit + 1));
    endtask

    task automatic check_after_done(input string tag);
        check({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_q = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check({tag, "_state"},  32'(dbg_state),          exp_q.pop_front());
        check({tag, "_busy"},   32'(bus.o_busy),         exp_q.pop_front());
        check({tag, "_done"},   32'(bus.o_done),         exp_q.pop_front());
        check({tag, "_err"},    32'(bus.o_err),          exp_q.pop_front());
        check({tag, "_result"}, 32'(bus.o_result),       exp_q.pop_front());
        check({tag, "_carry"},  32'(bus.o_carry),        exp_q.pop_front());
        check({tag, "_addr"},   32'(bus.o_imem_addr),    exp_q.pop_front());
        check({tag, "_op"},     32'(bus.o_alu_op),       exp_q.pop_front());
        check({tag, "_i1"},     32'(bus.o_alu_i_1),      exp_q.pop_front());
        check({tag, "_i2"},     32'(bus.o_alu_i_2),      exp_q.pop_front());
        check({tag, "_cin"},    32'(bus.o_alu_carry_in), exp_q.pop_front());
    endtask

    initial begin
        int cyc;
        logic done_seen;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_init  = 8'h00;
        poke_mask   = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // single ADD with halt
        clear_mem();
        mem[0] = ins(3'd0, 1'b0, 1'b1, 8'h05);
        start_prog(8'h10);
        wait_done(60, cyc);
        check("t1_cycles", 32'(cyc), 32'd4);
        check("t1_result", 32'(bus.o_result), 32'h15);
        check("t1_carry", 32'(bus.o_carry), 32'd0);
        check("t1_err", 32'(bus.o_err), 32'd0);
        check("t1_busy_run", 32'(busy_all), 32'd1);
        check_after_done("t1");

        // carry out then carry chained into the next ADD
        clear_mem();
        mem[0] = ins(3'd0, 1'b0, 1'b0, 8'h01);
        mem[1] = ins(3'd0, 1'b1, 1'b1, 8'h00);
        start_prog(8'hFF);
        wait_done(60, cyc);
        check("t2_cycles", 32'(cyc), 32'd7);
        check("t2_mid_acc", 32'(snap_res[4]), 32'h00);
        check("t2_mid_carry", 32'(snap_car[4]), 32'd1);
        check("t2_result", 32'(bus.o_result), 32'h01);
        check("t2_carry", 32'(bus.o_carry), 32'd0);
        check("t2_cin_used", 32'(cin_seen), 32'd1);
        check_after_done("t2");

        // SUB, LOAD, NOT
        clear_mem();
        mem[0] = ins(3'd1, 1'b0, 1'b0, 8'h03);
        mem[1] = ins(3'd6, 1'b0, 1'b0, 8'hA5);
        mem[2] = ins(3'd5, 1'b0, 1'b1, 8'h00);
        start_prog(8'h10);
        wait_done(60, cyc);
        check("t3_cycles", 32'(cyc), 32'd10);
        check("t3_mid_sub", 32'(snap_res[4]), 32'h0D);
        check("t3_mid_load", 32'(snap_res[7]), 32'hA5);
        check("t3_result", 32'(bus.o_result), 32'h5A);
        check("t3_carry", 32'(bus.o_carry), 32'd0);
        check("t3_cin_zero", 32'(cin_seen), 32'd0);
        check_after_done("t3");

        // run off the end of memory
        for (int i = 0; i < 16; i++) mem[i] = ins(3'd0, 1'b0, 1'b0, 8'h01);
        start_prog(8'h00);
        wait_done(60, cyc);
        check("t4_cycles", 32'(cyc), 32'd49);
        check("t4_result", 32'(bus.o_result), 32'h10);
        check("t4_err", 32'(bus.o_err), 32'd1);
        check("t4_addr", 32'(bus.o_imem_addr), 32'd15);
        check_after_done("t4");

        // start pulses while busy are ignored; err cleared by the new start
        clear_mem();
        mem[0] = ins(3'd0, 1'b0, 1'b0, 8'h01);
        mem[1] = ins(3'd0, 1'b1, 1'b1, 8'h00);
        poke_mask = 64'h0000_0000_0000_0024;
        start_prog(8'hFF);
        check("t5_err_cleared", 32'(bus.o_err), 32'd0);
        wait_done(60, cyc);
        poke_mask = '0;
        check("t5_cycles", 32'(cyc), 32'd7);
        check("t5_result", 32'(bus.o_result), 32'h01);
        check_after_done("t5");
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_requeue", 32'(dbg_state), 32'd0);

        // reset in LOAD_IR of instruction 1
        clear_mem();
        mem[0] = ins(3'd1, 1'b0, 1'b0, 8'h03);
        mem[1] = ins(3'd6, 1'b0, 1'b0, 8'hA5);
        mem[2] = ins(3'd5, 1'b0, 1'b1, 8'h00);
        start_prog(8'h10);
        repeat (4) @(posedge clk);
        #1;
        check("t6_in_load_ir", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("t6_rst");
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            done_seen = done_seen | bus.o_done;
            @(posedge clk);
            #1;
        end
        check("t6_no_done", 32'(done_seen), 32'd0);
        start_prog(8'h10);
        wait_done(60, cyc);
        check("t6_cycles", 32'(cyc), 32'd10);
        check("t6_result", 32'(bus.o_result), 32'h5A);
        check_after_done("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
